alu_ctrl_seq: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder.
- Combines ALUOp/funct decode, a registered ALU datapath, and a sequenced multi-cycle unsigned multiplier behind a start/done handshake.
- Sits between the main control unit and the register file write-back of the MIPS-lite datapath.
- Lets multi-cycle ops stall the datapath on busy; single-cycle ops keep a fixed 1-cycle latency.

---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_mul_seq.sv | 54 +++++
 rtl/alu_ctrl_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, FSM state encoding and the ALUOp/funct decode function.
// Pure declarations; no timing or flow-control behaviour of its own.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_MULT = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] gout;
        logic       illegal;
    } dec_t;

    function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [3:0] funct);
        dec_t d;
        d.gout    = ALU_ADD;
        d.illegal = 1'b0;
        if (aluop == 2'b00) begin
            d.gout = ALU_ADD;
        end else if (aluop == 2'b01) begin
            d.gout = ALU_SUB;
        end else begin
            case (funct)
                4'b0000: d.gout = ALU_ADD;
                4'b1010: d.gout = ALU_SLT;
                4'b0010: d.gout = ALU_SUB;
                4'b0101: d.gout = ALU_OR;
                4'b0100: d.gout = ALU_AND;
                4'b1101: d.gout = ALU_NOR;
                4'b1000: d.gout = ALU_MULT;
                default: begin
                    // Unknown R-type funct falls back to ADD so the datapath stays defined.
                    d.gout    = ALU_ADD;
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier datapath: one iteration per step, product {hi,lo} after WIDTH steps.
// Exposes the post-step product combinationally so the caller can capture it on the final step; no flow control.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic [WIDTH-1:0] prod_hi_nxt,
    output logic [WIDTH-1:0] prod_lo_nxt
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH:0]   sum;

    // The multiplier register doubles as the low half of the product as it shifts out.
    always_comb begin
        sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod_hi_nxt = sum[WIDTH:1];
        prod_lo_nxt = {sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (load) begin
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            acc_d    = '0;
        end else if (step) begin
            acc_d    = prod_hi_nxt;
            mplier_d = prod_lo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decode + registered ALU + sequenced multiplier; done 1 cycle after start (MULT: WIDTH+1).
// start is ignored while busy, nothing is queued; `define OVF_DETECT_EN adds a registered signed-overflow flag ovf.
import alu_ctrl_pkg::*;

module alu_ctrl_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       gout,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
`ifdef OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);

    dec_t             dec;
    logic [WIDTH-1:0] add_res, sub_res, alu_res;
    logic             slt;
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        dec     = alu_decode(aluop, funct);
        add_res = a + b;
        sub_res = a - b;
        slt     = $signed(a) < $signed(b);
        case (dec.gout)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = add_res;
            ALU_SUB: alu_res = sub_res;
            ALU_NOR: alu_res = ~(a | b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = '0;
        endcase
    end

    assign gout    = dec.gout;
    assign illegal = dec.illegal;

`ifdef OVF_DETECT_EN
    logic op_ovf;
    logic ovf_q, ovf_d;

    // Signed overflow: result sign disagrees with what the operand signs allow.
    always_comb begin
        case (dec.gout)
            ALU_ADD: op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
            ALU_SUB: op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            default: op_ovf = 1'b0;
        endcase
    end
`endif

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .load       (mul_load),
        .step       (mul_step),
        .mcand_in   (a),
        .mplier_in  (b),
        .prod_hi_nxt(mul_hi_nxt),
        .prod_lo_nxt(mul_lo_nxt)
    );

    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
`ifdef OVF_DETECT_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dec.gout == ALU_MULT) begin
                        mul_load = 1'b1;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
`ifdef OVF_DETECT_EN
                        ovf_d    = op_ovf;
`endif
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Capture the product on the final iteration so it is valid alongside done.
                if (mul_last) begin
                    result_d = mul_lo_nxt;
                    hi_d     = mul_hi_nxt;
                    zero_d   = (mul_lo_nxt == '0);
`ifdef OVF_DETECT_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef OVF_DETECT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef OVF_DETECT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef OVF_DETECT_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with an operation-level reference model checked every cycle.
module tb_alu_ctrl_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [3:0]   funct = 4'b0000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   gout;
    logic [W-1:0] result, hi;
    logic         zero, busy, done, illegal;
`ifdef OVF_DETECT_EN
    logic         ovf;
`endif

    alu_ctrl_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .aluop  (aluop),
        .funct  (funct),
        .a      (a),
        .b      (b),
        .gout   (gout),
        .result (result),
        .hi     (hi),
        .zero   (zero),
        .busy   (busy),
        .done   (done),
        .illegal(illegal)
`ifdef OVF_DETECT_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode and arithmetic, stated directly from the operation table.
    function automatic logic [2:0] ref_gout(input logic [1:0] op, input logic [3:0] fn);
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        case (fn)
            4'b0000: return 3'b010;
            4'b1010: return 3'b111;
            4'b0010: return 3'b110;
            4'b0101: return 3'b001;
            4'b0100: return 3'b000;
            4'b1101: return 3'b011;
            4'b1000: return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [1:0] op, input logic [3:0] fn);
        return op[1] && !(fn inside {4'd0, 4'd10, 4'd2, 4'd5, 4'd4, 4'd13, 4'd8});
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [2:0] g, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        case (g)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return W'(sx + sy);
            3'b110:  return W'(sx - sy);
            3'b011:  return ~(x | y);
            3'b111:  return (sx < sy) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] g, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s;
        if (g == 3'b010)      s = sx + sy;
        else if (g == 3'b110) s = sx - sy;
        else                  return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Operation-level model: accepted op, countdown to completion, held results.
    logic         m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1, m_ovf = 1'b0;
    logic [W-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
    int           m_rem = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b1; m_ovf <= 1'b0;
            m_res  <= '0;   m_hi   <= '0;   m_rem  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_res  <= p_res;
                m_hi   <= p_hi;
                m_zero <= (p_res == 0);
                m_ovf  <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (start) begin
            if (ref_gout(aluop, funct) == 3'b100) begin
                {p_hi, p_res} <= 64'(a) * 64'(b);
                m_busy <= 1'b1;
                m_rem  <= W;
            end else begin
                m_res  <= ref_alu(ref_gout(aluop, funct), a, b);
                m_zero <= (ref_alu(ref_gout(aluop, funct), a, b) == 0);
                m_ovf  <= ref_ovf(ref_gout(aluop, funct), a, b);
                m_busy <= 1'b1;
                m_done <= 1'b1;
            end
        end
    end

    // Every cycle: advance to the falling edge and compare all registered outputs with the model.
    task automatic tick();
        @(negedge clk);
        chk("busy",   64'(busy),   64'(m_busy));
        chk("done",   64'(done),   64'(m_done));
        chk("result", 64'(result), 64'(m_res));
        chk("hi",     64'(hi),     64'(m_hi));
        chk("zero",   64'(zero),   64'(m_zero));
`ifdef OVF_DETECT_EN
        chk("ovf",    64'(ovf),    64'(m_ovf));
`endif
    endtask

    // Issue one op, scramble operands after acceptance, optionally pulse start at cycle pulse_at.
    task automatic run_op(input logic [1:0] op, input logic [3:0] fn, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int exp_lat, input int pulse_at);
        int cyc = 0;
        bit got = 0;
        tick();
        #1;
        aluop = op; funct = fn; a = av; b = bv; start = 1'b1;
        while (!got && cyc < exp_lat + 4) begin
            tick();
            cyc++;
            if (done === 1'b1) got = 1;
            #1;
            start = (cyc == pulse_at);
            a = $urandom;
            b = $urandom;
        end
        chk("latency", 64'(cyc), 64'(exp_lat));
        tick();
        #1;
        start = 1'b0;
    endtask

    initial begin
        int npulse;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", 64'(result), 64'h0);
        chk("rst_hi",     64'(hi),     64'h0);
        chk("rst_zero",   64'(zero),   64'h1);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_done",   64'(done),   64'h0);
        reset = 1'b0;

        run_op(2'b10, 4'b0000, 32'd5, 32'd7, 1, 0);
        chk("add_res", 64'(result), 64'd12);
        chk("add_zero", 64'(zero), 64'h0);

        run_op(2'b10, 4'b0010, 32'd9, 32'd9, 1, 1);
        chk("sub_res", 64'(result), 64'h0);
        chk("sub_zero", 64'(zero), 64'h1);

        run_op(2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1, 1, 0);
        chk("slt_res", 64'(result), 64'h1);

        run_op(2'b10, 4'b0100, 32'hF0F0_0000, 32'hFF00_FF00, 1, 0);
        chk("and_res", 64'(result), 64'hF000_0000);
        run_op(2'b10, 4'b0101, 32'hF0F0_0000, 32'hFF00_FF00, 1, 0);
        chk("or_res", 64'(result), 64'hFFF0_FF00);
        run_op(2'b10, 4'b1101, 32'hF0F0_0000, 32'hFF00_FF00, 1, 0);
        chk("nor_res", 64'(result), 64'h000F_00FF);

        run_op(2'b10, 4'b1000, 32'hFFFF_FFFF, 32'd2, W + 1, 10);
        chk("mul_hi", 64'(hi), 64'h1);
        chk("mul_lo", 64'(result), 64'hFFFF_FFFE);

        run_op(2'b00, 4'b1111, 32'd3, 32'd4, 1, 0);
        chk("add00_res", 64'(result), 64'd7);
        chk("hi_held", 64'(hi), 64'h1);
        run_op(2'b01, 4'b0000, 32'd3, 32'd4, 1, 0);
        chk("sub01_res", 64'(result), 64'hFFFF_FFFF);

        run_op(2'b11, 4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, W + 1, 0);

        aluop = 2'b00; funct = 4'b1010; #1;
        chk("dec_00_gout", 64'(gout), 64'h2);
        aluop = 2'b01; #1;
        chk("dec_01_gout", 64'(gout), 64'h6);
        aluop = 2'b10; funct = 4'b1111; #1;
        chk("dec_ill_flag", 64'(illegal), 64'h1);
        chk("dec_ill_gout", 64'(gout), 64'h2);
        for (int op = 0; op < 4; op++) begin
            for (int fn = 0; fn < 16; fn++) begin
                aluop = 2'(op); funct = 4'(fn); #1;
                chk("dec_gout", 64'(gout), 64'(ref_gout(2'(op), 4'(fn))));
                chk("dec_illegal", 64'(illegal), 64'(ref_illegal(2'(op), 4'(fn))));
            end
        end

`ifdef OVF_DETECT_EN
        run_op(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'd1, 1, 0);
        chk("ovf_set", 64'(ovf), 64'h1);
        chk("ovf_res", 64'(result), 64'h8000_0000);
        run_op(2'b10, 4'b0000, 32'd1, 32'd1, 1, 0);
        chk("ovf_clr", 64'(ovf), 64'h0);
`endif

        // Abort a multiply mid-flight with reset.
        tick();
        #1;
        aluop = 2'b10; funct = 4'b1000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        #1;
        start = 1'b0;
        repeat (5) tick();
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy",   64'(busy),   64'h0);
        chk("abort_done",   64'(done),   64'h0);
        chk("abort_hi",     64'(hi),     64'h0);
        chk("abort_result", 64'(result), 64'h0);
        tick();
        #1;
        reset = 1'b0;
        npulse = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) npulse++;
        end
        chk("abort_no_done", 64'(npulse), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
